mmio_result_port: RTL and testbench

MMIO_RESULT_PORT -- requirements
Module: mmio_result_port

---
 rtl/mmio_result_port.sv | 165 ++++++++++++++++
 tb/tb_mmio_result_port.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_result_port.sv
// Memory-mapped result port: a character FIFO and NUM_CH 64-bit result channels
// that commit atomically when the MSB word is written.
module mmio_result_port #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_valid,
  input  logic [31:0]            mem_addr,
  input  logic [31:0]            mem_wdata,
  input  logic [3:0]             mem_wstrb,
  output logic                   mem_ready,
  output logic [31:0]            mem_rdata,
  output logic [7:0]             out_byte,
  output logic                   out_byte_valid,
  input  logic                   out_byte_ready,
  output logic [NUM_CH*64-1:0]   out_ch,
  output logic [NUM_CH-1:0]      out_ch_valid
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              r_err;
  logic              r_ready;
  logic [31:0]       r_rdata;
  logic [31:0]       r_stage [NUM_CH];
  logic [63:0]       r_ch [NUM_CH];
  logic [NUM_CH-1:0] r_ch_valid;

  logic [7:0]        w_off;
  logic              w_sel;
  logic              w_wr;
  logic              w_is_data;
  logic              w_is_stat;
  logic [NUM_CH-1:0] w_ch_sel;
  logic              w_ch_hit;
  logic              w_ch_hi;
  logic              w_bad;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_stall;
  logic              w_ack;
  logic [8:0]        w_cnt9;
  logic [31:0]       w_rd;

  function automatic logic [31:0] f_merge(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int unsigned b = 0; b < 4; b++)
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    return res;
  endfunction

  // r_ready gates selection so a request still held during its ack cycle is not re-acked
  assign w_sel     = mem_valid && (mem_addr[31:8] == BASE_ADDR[31:8]) && !r_ready;
  assign w_off     = mem_addr[7:0];
  assign w_wr      = |mem_wstrb;
  assign w_is_data = (w_off == 8'h00);
  assign w_is_stat = (w_off == 8'h04);
  assign w_ch_hi   = w_off[2];

  always_comb begin
    w_ch_sel = '0;
    for (int unsigned i = 0; i < NUM_CH; i++)
      if (w_off[1:0] == 2'b00 && w_off[7:3] == 5'(2 + i)) w_ch_sel[i] = 1'b1;
  end

  assign w_ch_hit = |w_ch_sel;
  assign w_bad    = !w_is_data && !w_is_stat && !w_ch_hit;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CW'(FIFO_DEPTH));
  assign w_pop    = !w_empty && out_byte_ready;
  // A full FIFO still accepts the push when a pop frees the slot on the same edge
  assign w_stall  = w_sel && w_is_data && mem_wstrb[0] && w_full && !w_pop;
  assign w_ack    = w_sel && !w_stall;
  assign w_push   = w_ack && w_is_data && mem_wstrb[0];
  assign w_cnt9   = 9'(r_count);

  always_comb begin
    w_rd = '0;
    if (w_is_stat) w_rd = {r_err, 15'd0, w_cnt9[7:0], 6'd0, w_full, w_empty};
    for (int unsigned i = 0; i < NUM_CH; i++)
      if (w_ch_sel[i]) w_rd = w_ch_hi ? r_ch[i][63:32] : r_ch[i][31:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= w_ack;
      r_rdata <= (w_ack && !w_wr) ? w_rd : '0;
      if (w_ack && w_bad)
        r_err <= 1'b1;
      else if (w_ack && w_wr && w_is_stat && mem_wdata[31])
        r_err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_wptr] <= mem_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ch_valid <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_stage[i] <= '0;
        r_ch[i]    <= '0;
      end
    end else begin
      r_ch_valid <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (w_ack && w_wr && w_ch_sel[i]) begin
          if (!w_ch_hi) begin
            r_stage[i] <= f_merge(r_stage[i], mem_wdata, mem_wstrb);
          end else begin
            r_ch[i]       <= {f_merge(r_ch[i][63:32], mem_wdata, mem_wstrb), r_stage[i]};
            r_ch_valid[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign mem_ready      = r_ready;
  assign mem_rdata      = r_rdata;
  assign out_byte_valid = !w_empty;
  assign out_byte       = w_empty ? '0 : r_mem[r_rptr];
  assign out_ch_valid   = r_ch_valid;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign out_ch[64*g +: 64] = r_ch[g];
  end

endmodule

// File: tb/tb_mmio_result_port.sv
// Bench for mmio_result_port: queue-based reference model checked every cycle,
// plus directed transactions with literal expectations.
module tb_mmio_result_port;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          NCH   = 2;
  localparam int          DEPTH = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           mem_valid;
  logic [31:0]    mem_addr;
  logic [31:0]    mem_wdata;
  logic [3:0]     mem_wstrb;
  logic           mem_ready;
  logic [31:0]    mem_rdata;
  logic [7:0]     out_byte;
  logic           out_byte_valid;
  logic           out_byte_ready;
  logic [NCH*64-1:0] out_ch;
  logic [NCH-1:0] out_ch_valid;

  mmio_result_port #(.BASE_ADDR(BASE), .NUM_CH(NCH), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .out_byte(out_byte), .out_byte_valid(out_byte_valid),
    .out_byte_ready(out_byte_ready), .out_ch(out_ch), .out_ch_valid(out_ch_valid)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Reference model state
  logic [7:0]     mq[$];
  logic [63:0]    m_ch[NCH];
  logic [31:0]    m_stage[NCH];
  logic           m_err      = 1'b0;
  logic           exp_ready  = 1'b0;
  logic           exp_isrd   = 1'b0;
  logic [31:0]    exp_rdata  = '0;
  logic [NCH-1:0] exp_strobe = '0;
  logic           started    = 1'b0;
  logic [7:0]     pop_log[$];

  function automatic logic [31:0] mask_merge(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~m) | (n & m);
  endfunction

  always @(posedge clk) begin : model
    logic pop, sel, ack, wr, push;
    logic [7:0] off;
    logic [31:0] rd;
    int unsigned n, ch;
    exp_strobe = '0;
    if (reset) begin
      mq.delete();
      for (int i = 0; i < NCH; i++) begin m_ch[i] = '0; m_stage[i] = '0; end
      m_err = 1'b0; exp_ready = 1'b0; exp_isrd = 1'b0; exp_rdata = '0;
    end else begin
      n    = mq.size();
      pop  = out_byte_ready && n > 0;
      sel  = mem_valid && (mem_addr[31:8] == BASE[31:8]) && !exp_ready;
      off  = mem_addr[7:0];
      wr   = (mem_wstrb != 4'b0);
      ack  = sel;
      push = 1'b0;
      rd   = '0;
      if (sel) begin
        if (off == 8'h00) begin
          if (wr && mem_wstrb[0]) begin
            if (n == DEPTH && !pop) ack = 1'b0;
            else push = 1'b1;
          end
        end else if (off == 8'h04) begin
          if (!wr) rd = {m_err, 15'd0, 8'(n % 256), 6'd0, n == DEPTH, n == 0};
          else if (mem_wdata[31]) m_err = 1'b0;
        end else if (off >= 8'h10 && int'(off) < 16 + 8 * NCH && off[1:0] == 2'b00) begin
          ch = (int'(off) - 16) / 8;
          if (!wr) rd = (off % 8 == 4) ? m_ch[ch][63:32] : m_ch[ch][31:0];
          else if (off % 8 == 0) m_stage[ch] = mask_merge(m_stage[ch], mem_wdata, mem_wstrb);
          else begin
            m_ch[ch] = {mask_merge(m_ch[ch][63:32], mem_wdata, mem_wstrb), m_stage[ch]};
            exp_strobe[ch] = 1'b1;
          end
        end else begin
          m_err = 1'b1;
        end
      end
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(mem_wdata[7:0]);
      exp_ready = ack;
      exp_isrd  = ack && !wr;
      exp_rdata = rd;
    end
  end

  always @(negedge clk) begin : compare
    logic [7:0] head;
    if (started) begin
      head = (mq.size() > 0) ? mq[0] : 8'h00;
      chk("mem_ready", 128'(mem_ready), 128'(exp_ready));
      if (exp_ready && exp_isrd) chk("mem_rdata", 128'(mem_rdata), 128'(exp_rdata));
      chk("out_byte_valid", 128'(out_byte_valid), 128'(mq.size() > 0));
      chk("out_byte", 128'(out_byte), 128'(head));
      chk("out_ch", 128'(out_ch), {m_ch[1], m_ch[0]});
      chk("out_ch_valid", 128'(out_ch_valid), 128'(exp_strobe));
      if (out_byte_valid && out_byte_ready) pop_log.push_back(out_byte);
    end
  end

  task automatic start_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
  endtask

  task automatic wait_ack(input int maxc, output logic got, output logic [31:0] rd);
    got = 1'b0; rd = '0;
    for (int i = 0; i < maxc && !got; i++) begin
      @(posedge clk); #1;
      if (mem_ready) begin got = 1'b1; rd = mem_rdata; end
    end
    if (got) mem_valid = 1'b0;
  endtask

  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rd);
    logic got;
    start_req(a, d, s);
    wait_ack(20, got, rd);
    chk("bus_ack", 128'(got), 128'(1));
    mem_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic got;
    reset = 1'b1; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    out_byte_ready = 1'b0;
    @(posedge clk); #1 started = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("reset_out_ch", 128'(out_ch), 128'(0));
    bus(BASE + 32'h04, 0, 4'h0, rd);
    chk("reset_status", 128'(rd), 128'h0000_0001);

    // Two characters streamed out with the consumer always ready
    out_byte_ready = 1'b1;
    pop_log.delete();
    bus(BASE, 32'h48, 4'h1, rd);
    chk("char0_head", 128'(out_byte), 128'h48);
    bus(BASE, 32'h69, 4'h1, rd);
    chk("char1_head", 128'(out_byte), 128'h69);
    @(posedge clk); #1;
    chk("chars_drained", 128'(out_byte_valid), 128'(0));
    chk("pop_count", 128'(pop_log.size()), 128'(2));
    if (pop_log.size() == 2) begin
      chk("pop_seq0", 128'(pop_log[0]), 128'h48);
      chk("pop_seq1", 128'(pop_log[1]), 128'h69);
    end
    out_byte_ready = 1'b0;

    // Channel 0 commit, then a byte-0-only MSB update
    bus(BASE + 32'h10, 32'h89AB_CDEF, 4'hF, rd);
    chk("lsb_no_commit", 128'(out_ch[63:0]), 128'(0));
    bus(BASE + 32'h14, 32'h0123_4567, 4'hF, rd);
    chk("ch0_commit", 128'(out_ch[63:0]), 128'h0123_4567_89AB_CDEF);
    chk("ch0_strobe", 128'(out_ch_valid), 128'b01);
    @(posedge clk); #1;
    chk("ch0_strobe_once", 128'(out_ch_valid), 128'(0));
    bus(BASE + 32'h10, 0, 4'h0, rd);
    chk("ch0_rd_lo", 128'(rd), 128'h89AB_CDEF);
    bus(BASE + 32'h14, 0, 4'h0, rd);
    chk("ch0_rd_hi", 128'(rd), 128'h0123_4567);
    bus(BASE + 32'h14, 32'h0000_00FF, 4'b0001, rd);
    chk("ch0_partial", 128'(out_ch[63:0]), 128'h0123_45FF_89AB_CDEF);
    chk("ch0_partial_strobe", 128'(out_ch_valid), 128'b01);

    bus(BASE + 32'h18, 32'hDEAD_BEEF, 4'b0011, rd);
    bus(BASE + 32'h1C, 32'h1234_5678, 4'hF, rd);
    chk("ch1_commit", 128'(out_ch[127:64]), 128'h1234_5678_0000_BEEF);

    // Data write without byte 0 strobe acks but pushes nothing; data read is 0
    bus(BASE, 32'h0000_5500, 4'b0010, rd);
    chk("nopush", 128'(out_byte_valid), 128'(0));
    bus(BASE, 0, 4'h0, rd);
    chk("data_rd_zero", 128'(rd), 128'(0));

    // Request outside the window is ignored
    start_req(32'h2000_0000, 32'h1, 4'h1);
    wait_ack(4, got, rd);
    chk("unsel_noack", 128'(got), 128'(0));
    mem_valid = 1'b0;

    // Error flag: unmapped offset, clear, unmapped channel
    bus(BASE + 32'h80, 0, 4'h0, rd);
    chk("bad_rd_zero", 128'(rd), 128'(0));
    bus(BASE + 32'h04, 0, 4'h0, rd);
    chk("err_set", 128'(rd), 128'h8000_0001);
    bus(BASE + 32'h04, 32'h8000_0000, 4'hF, rd);
    bus(BASE + 32'h04, 0, 4'h0, rd);
    chk("err_clear", 128'(rd), 128'h0000_0001);
    bus(BASE + 32'h20, 32'hFFFF_FFFF, 4'hF, rd);
    bus(BASE + 32'h04, 0, 4'h0, rd);
    chk("err_ch2", 128'(rd), 128'h8000_0001);
    bus(BASE + 32'h04, 32'h8000_0000, 4'hF, rd);

    // Fill to full, stall the extra write, release it with one pop
    for (int i = 0; i < DEPTH; i++) bus(BASE, 32'hA0 + 32'(i), 4'h1, rd);
    bus(BASE + 32'h04, 0, 4'h0, rd);
    chk("full_status", 128'(rd), 128'h0000_1002);
    start_req(BASE, 32'hEE, 4'h1);
    wait_ack(5, got, rd);
    chk("stall_noack", 128'(got), 128'(0));
    out_byte_ready = 1'b1;
    wait_ack(3, got, rd);
    out_byte_ready = 1'b0;
    chk("stall_release", 128'(got), 128'(1));
    mem_valid = 1'b0;
    bus(BASE + 32'h04, 0, 4'h0, rd);
    chk("full_after_release", 128'(rd), 128'h0000_1002);
    out_byte_ready = 1'b1;
    repeat (DEPTH + 4) @(posedge clk);
    #1 chk("drained", 128'(out_byte_valid), 128'(0));
    out_byte_ready = 1'b0;

    // Reset during a stalled push
    for (int i = 0; i < DEPTH; i++) bus(BASE, 32'h30 + 32'(i), 4'h1, rd);
    start_req(BASE, 32'h77, 4'h1);
    wait_ack(3, got, rd);
    chk("stall2_noack", 128'(got), 128'(0));
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_stall_ready", 128'(mem_ready), 128'(0));
    chk("rst_stall_empty", 128'(out_byte_valid), 128'(0));
    chk("rst_stall_out_ch", 128'(out_ch), 128'(0));
    mem_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    bus(BASE + 32'h04, 0, 4'h0, rd);
    chk("rst_status", 128'(rd), 128'h0000_0001);

    // Reset in the cycle a commit would happen
    bus(BASE + 32'h10, 32'h1111_1111, 4'hF, rd);
    bus(BASE + 32'h14, 32'h2222_2222, 4'hF, rd);
    chk("pre_rst_commit", 128'(out_ch[63:0]), 128'h2222_2222_1111_1111);
    bus(BASE + 32'h10, 32'h5555_5555, 4'hF, rd);
    @(posedge clk); #1;
    start_req(BASE + 32'h14, 32'h6666_6666, 4'hF);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_commit_strobe", 128'(out_ch_valid), 128'(0));
    chk("rst_commit_out_ch", 128'(out_ch), 128'(0));
    chk("rst_commit_ready", 128'(mem_ready), 128'(0));
    mem_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    bus(BASE + 32'h14, 32'h0000_0033, 4'hF, rd);
    chk("stage_cleared", 128'(out_ch[63:0]), 128'h0000_0033_0000_0000);

    repeat (3) @(posedge clk);
    #1 $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
